haar_database_loader: RTL and testbench
=======================================

// Module: haar_database_loader
// PURPOSE
// - Write side of the Haar cascade database: parses a 16-bit word stream (host/flash DMA) into the flat
//   database memory that the classifier reads (threshold/left/right per feature + per-stage threshold).
// - Sits between the external parameter source and the classifier's database RAM; classifier stays idle until done.
// PARAMETERS
// - DATA_WIDTH_16   16   stream word and memory data width
// - MEM_SIZE        100  database memory depth (words)
// - ADDR_WIDTH      7    memory address width; must satisfy 2**ADDR_WIDTH >= MEM_SIZE
// - MAX_STAGES      16   maximum accepted stage count
// - STAGE_IDX_WIDTH 4    width of stage index, must satisfy 2**STAGE_IDX_WIDTH >= MAX_STAGES
// PORTS
// - clk          in   1            rising-edge clock
// - reset        in   1            synchronous, active-high reset
// - start        in   1            pulse: begin a load (ignored unless IDLE/DONE/ERROR)
// - in_valid     in   1            stream word valid
// - in_ready     out  1            loader can accept word
// - in_data      in   16           stream word
// - in_last      in   1            marks final word of the image
// - wr_en        out  1            database write strobe
// - wr_addr      out  ADDR_WIDTH   database write address
// - wr_data      out  16           database write data
// - stage_base_we   out 1          stage table write strobe
// - stage_base_idx  out STAGE_IDX_WIDTH  stage number being recorded
// - stage_base_addr out ADDR_WIDTH first database address of that stage
// - busy         out  1            load in progress
// - done         out  1            load completed OK (level, held until next start/reset)
// - error        out  1            load aborted (level, held until next start/reset)
// BEHAVIOUR
// - Stream format: NUM_STAGES; per stage: N (classifier count), N x {threshold,left,right}, STAGE_THR.
// - Transfer on in_valid & in_ready. in_ready=1 only in S_NSTG/S_HDR/S_FEAT/S_STHR (and S_CSUM if enabled).
// - Reset: state=S_IDLE; in_ready,wr_en,stage_base_we,busy,done,error=0; wr_addr,wr_data,stage_base_*=0.
// - FSM: S_IDLE -start-> S_NSTG -> S_HDR -> S_FEAT (3N words) -> S_STHR -> S_HDR (next stage) | end.
//   End = S_DONE, or S_CSUM then S_DONE when macro enabled. Any fault -> S_ERROR. start from DONE/ERROR restarts.
// - start clears done/error, address pointer=0, stage counter=0; busy=1 from next cycle until DONE/ERROR.
// - Only feature words and STAGE_THR are written; NUM_STAGES and N are not stored.
// - Write latency: wr_en/wr_addr/wr_data registered, asserted exactly 1 cycle after the accepting edge;
//   address increments by 1 per write, no gaps. Memory never back-pressures.
// - Accepting a stage's N word: stage_base_we pulses 1 cycle later with idx=stage count, addr=current pointer.
// - N=0: S_HDR -> S_STHR directly (stage holds only its threshold word).
// - NUM_STAGES=0: must carry in_last; -> S_DONE, no writes. NUM_STAGES>MAX_STAGES -> S_ERROR.
// - Overflow: write that would reach address MEM_SIZE -> S_ERROR, that write suppressed.
// - in_last on any word except final expected word -> S_ERROR; final word without in_last -> S_ERROR.
// - Feature-word counter is 2 bits (0..2) plus a classifier counter 0..N-1; 16-bit N, no saturation.
// - start while busy ignored. Reset mid-load aborts immediately; memory contents left as partially written.
// - In S_DONE/S_ERROR/S_IDLE in_ready=0; extra stream words are not consumed.
// CONFIGURATION
// - LOADER_CHECKSUM_EN defined: after final STAGE_THR expect one checksum word = 16-bit wrapping sum of
//   all preceding stream words (NUM_STAGES included); in_last moves to the checksum word; mismatch -> S_ERROR,
//   done never asserted. Checksum word is not written to memory.
// - Undefined: no checksum state; final STAGE_THR carries in_last; no accumulator logic synthesised.
// TESTING
// - 1 stage, N=1: words 1,1,0x0010,0x0020,0x0030,0x0040(last) -> writes addr0..3 = 0x10,0x20,0x30,0x40;
//   stage_base idx0 addr0; done=1 one cycle after last write; error=0.
// - 2 stages N=2,N=0 with in_valid toggled every other cycle -> 8 contiguous writes addr0..7; stage_base
//   (0,0) and (1,7); wr_addr never skips.
// - MEM_SIZE=4, 1 stage N=2 -> 4 writes OK then 5th suppressed, error=1, done=0, in_ready=0.
// - in_last on 2nd feature word -> error=1 next cycle; start then valid 1-stage image -> done=1, error=0.
// - reset asserted mid-S_FEAT -> next cycle all outputs at reset values; start restarts at addr0.
// - LOADER_CHECKSUM_EN: image of test 1 + checksum 0x00A2 -> done; checksum 0x00A3 -> error.

Source files
------------

// File: rtl/haar_database_loader.sv
// Haar cascade database loader: parses NUM_STAGES / N / {thr,left,right}xN / STAGE_THR words into database writes.
// Latency: wr_* and stage_base_* are registered, one cycle after the accepting edge; the database never stalls.
// Backpressure: in_ready only while parsing; LOADER_CHECKSUM_EN adds a trailing 16-bit sum word carrying in_last.
module haar_database_loader #(
    parameter int DATA_WIDTH_16   = 16,
    parameter int MEM_SIZE        = 100,
    parameter int ADDR_WIDTH      = 7,
    parameter int MAX_STAGES      = 16,
    parameter int STAGE_IDX_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH_16-1:0]   in_data,
    input  logic                       in_last,
    output logic                       wr_en,
    output logic [ADDR_WIDTH-1:0]      wr_addr,
    output logic [DATA_WIDTH_16-1:0]   wr_data,
    output logic                       stage_base_we,
    output logic [STAGE_IDX_WIDTH-1:0] stage_base_idx,
    output logic [ADDR_WIDTH-1:0]      stage_base_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NSTG,
        S_HDR,
        S_FEAT,
        S_STHR,
        S_DONE,
        S_ERROR
`ifdef LOADER_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    localparam logic [ADDR_WIDTH:0]      MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH:0]      PTR_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [STAGE_IDX_WIDTH:0] STG_ONE   = (STAGE_IDX_WIDTH+1)'(1);
    localparam logic [DATA_WIDTH_16-1:0] MAX_STG   = DATA_WIDTH_16'(MAX_STAGES);
    localparam logic [DATA_WIDTH_16-1:0] CLS_ONE   = DATA_WIDTH_16'(1);

    state_t                     state, state_nxt, end_state;
    // One extra pointer bit so a completely full memory is distinguishable from address 0.
    logic [ADDR_WIDTH:0]        ptr, ptr_nxt;
    logic [STAGE_IDX_WIDTH:0]   stage_cnt, stage_cnt_nxt;
    logic [STAGE_IDX_WIDTH:0]   num_stg, num_stg_nxt;
    logic [DATA_WIDTH_16-1:0]   n_cls, n_cls_nxt;
    logic [DATA_WIDTH_16-1:0]   cls_cnt, cls_cnt_nxt;
    logic [1:0]                 feat_cnt, feat_cnt_nxt;
    logic                       wr_en_nxt, sb_we_nxt;
    logic [ADDR_WIDTH-1:0]      wr_addr_nxt, sb_addr_nxt;
    logic [DATA_WIDTH_16-1:0]   wr_data_nxt;
    logic [STAGE_IDX_WIDTH-1:0] sb_idx_nxt;
    logic                       xfer, room, last_stage, last_cls, do_write, parse_state;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH_16-1:0]   sum, sum_nxt;
`endif

    assign parse_state = (state == S_NSTG) || (state == S_HDR) || (state == S_FEAT) || (state == S_STHR)
`ifdef LOADER_CHECKSUM_EN
                         || (state == S_CSUM)
`endif
                         ;
    assign in_ready = parse_state;
    assign busy     = parse_state;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            ptr             <= '0;
            stage_cnt       <= '0;
            num_stg         <= '0;
            n_cls           <= '0;
            cls_cnt         <= '0;
            feat_cnt        <= '0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            wr_data         <= '0;
            stage_base_we   <= 1'b0;
            stage_base_idx  <= '0;
            stage_base_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum             <= '0;
`endif
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            stage_cnt       <= stage_cnt_nxt;
            num_stg         <= num_stg_nxt;
            n_cls           <= n_cls_nxt;
            cls_cnt         <= cls_cnt_nxt;
            feat_cnt        <= feat_cnt_nxt;
            wr_en           <= wr_en_nxt;
            wr_addr         <= wr_addr_nxt;
            wr_data         <= wr_data_nxt;
            stage_base_we   <= sb_we_nxt;
            stage_base_idx  <= sb_idx_nxt;
            stage_base_addr <= sb_addr_nxt;
`ifdef LOADER_CHECKSUM_EN
            sum             <= sum_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        stage_cnt_nxt = stage_cnt;
        num_stg_nxt   = num_stg;
        n_cls_nxt     = n_cls;
        cls_cnt_nxt   = cls_cnt;
        feat_cnt_nxt  = feat_cnt;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = wr_addr;
        wr_data_nxt   = wr_data;
        sb_we_nxt     = 1'b0;
        sb_idx_nxt    = stage_base_idx;
        sb_addr_nxt   = stage_base_addr;
        do_write      = 1'b0;
        xfer          = in_valid && in_ready;
        room          = (ptr != MEM_LIMIT);
        last_stage    = ((stage_cnt + STG_ONE) == num_stg);
        last_cls      = (cls_cnt == (n_cls - CLS_ONE));
        // Where the image goes after its last stage-level word.
`ifdef LOADER_CHECKSUM_EN
        sum_nxt       = sum;
        if (xfer && (state != S_CSUM)) sum_nxt = sum + in_data;
        end_state     = in_last ? S_ERROR : S_CSUM;
`else
        end_state     = in_last ? S_DONE : S_ERROR;
`endif

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt     = S_NSTG;
                    ptr_nxt       = '0;
                    stage_cnt_nxt = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_nxt       = '0;
`endif
                end
            end
            S_NSTG: begin
                if (xfer) begin
                    num_stg_nxt = in_data[STAGE_IDX_WIDTH:0];
                    if (in_data > MAX_STG)    state_nxt = S_ERROR;
                    else if (in_data == '0)   state_nxt = end_state;
                    else                      state_nxt = in_last ? S_ERROR : S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_cls_nxt    = in_data;
                    cls_cnt_nxt  = '0;
                    feat_cnt_nxt = '0;
                    sb_we_nxt    = 1'b1;
                    sb_idx_nxt   = stage_cnt[STAGE_IDX_WIDTH-1:0];
                    sb_addr_nxt  = ptr[ADDR_WIDTH-1:0];
                    if (in_last)            state_nxt = S_ERROR;
                    else if (in_data == '0) state_nxt = S_STHR;
                    else                    state_nxt = S_FEAT;
                end
            end
            S_FEAT: begin
                if (xfer) begin
                    if (in_last || !room) begin
                        state_nxt = S_ERROR;
                    end else begin
                        do_write = 1'b1;
                        if (feat_cnt == 2'd2) begin
                            feat_cnt_nxt = 2'd0;
                            if (last_cls) state_nxt   = S_STHR;
                            else          cls_cnt_nxt = cls_cnt + CLS_ONE;
                        end else begin
                            feat_cnt_nxt = feat_cnt + 2'd1;
                        end
                    end
                end
            end
            S_STHR: begin
                if (xfer) begin
                    stage_cnt_nxt = stage_cnt + STG_ONE;
                    if (!room) begin
                        state_nxt = S_ERROR;
                    end else if (last_stage) begin
                        state_nxt = end_state;
                        do_write  = (end_state != S_ERROR);
                    end else if (in_last) begin
                        state_nxt = S_ERROR;
                    end else begin
                        state_nxt = S_HDR;
                        do_write  = 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) state_nxt = (in_last && (in_data == sum)) ? S_DONE : S_ERROR;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase

        if (do_write) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ptr[ADDR_WIDTH-1:0];
            wr_data_nxt = in_data;
            ptr_nxt     = ptr + PTR_ONE;
        end
    end

endmodule

// File: tb/tb_haar_database_loader.sv
// Bench for haar_database_loader: table-driven images, hand-written corner sequences and random images
// checked against a stream-level model of which words land where in the database.
module tb_haar_database_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic        in_ready, wr_en, stage_base_we, busy, done, error;
    logic [15:0] in_data, wr_data;
    logic [6:0]  wr_addr, stage_base_addr;
    logic [3:0]  stage_base_idx;

    int tests = 0;
    int failed = 0;

    logic [31:0] wq[$];
    logic [31:0] sq[$];
    logic [15:0] img_w[$];
    logic [15:0] exp_pay[$];
    logic [31:0] exp_sb[$];

    typedef struct {
        string name;
        int    nstg;
        int    n0;
        int    n1;
        int    stop_at;
        int    last_at;
        int    exp_writes;
        bit    exp_done;
        bit    exp_err;
    } vec_t;

    always #5 clk = ~clk;

    haar_database_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .stage_base_we(stage_base_we), .stage_base_idx(stage_base_idx), .stage_base_addr(stage_base_addr),
        .busy(busy), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (wr_en) wq.push_back({9'd0, wr_addr, wr_data});
        if (stage_base_we) sq.push_back({12'd0, stage_base_idx, 9'd0, stage_base_addr});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: the database receives every stream word except NUM_STAGES and N, in order from address 0;
    // each stage's base is the count of database words written before its N word.
    task automatic build(input int ns[$], input int nstg, input bit rnd);
        logic [15:0] v;
        logic [15:0] sum;
        int n;
        img_w.delete(); exp_pay.delete(); exp_sb.delete();
        img_w.push_back(16'(nstg));
        for (int s = 0; s < nstg; s++) begin
            n = ns[(s < ns.size()) ? s : ns.size() - 1];
            exp_sb.push_back({12'd0, 4'(s), 9'd0, 7'(exp_pay.size())});
            img_w.push_back(16'(n));
            for (int k = 0; k < 3 * n + 1; k++) begin
                v = rnd ? 16'($urandom) : 16'(32'h1000 + exp_pay.size());
                img_w.push_back(v);
                exp_pay.push_back(v);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        sum = 16'd0;
        foreach (img_w[i]) sum += img_w[i];
        img_w.push_back(sum);
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        wq.delete(); sq.delete();
        in_valid = 1'b0; in_last = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input logic l, input int gap);
        int t = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // gapmode: 0 back-to-back, 1 idle cycle between words, 2 random idles.
    task automatic run(input string name, input int ns[$], input int nstg, input bit rnd, input int gapmode,
                       input int stop_at, input int last_at, input int exp_writes,
                       input bit exp_done, input bit exp_err);
        int last;
        int gap;
        int nw;
        build(ns, nstg, rnd);
        pulse_start();
        last = (stop_at < 0) ? img_w.size() - 1 : stop_at;
        for (int i = 0; i <= last; i++) begin
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : $urandom_range(0, 2);
            send_word(img_w[i], (last_at == i) || (last_at == -1 && i == img_w.size() - 1), gap);
        end
        end_stream();
        check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
        check({name, "_error"}, {31'd0, error}, {31'd0, exp_err});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        if (exp_writes >= 0) begin
            check({name, "_nwrites"}, wq.size(), exp_writes);
            nw = (wq.size() < exp_writes) ? wq.size() : exp_writes;
            for (int i = 0; i < nw; i++)
                check({name, "_write"}, wq[i], {9'd0, 7'(i), exp_pay[i]});
        end
        if (exp_done) begin
            check({name, "_nstage_base"}, sq.size(), exp_sb.size());
            for (int i = 0; i < sq.size() && i < exp_sb.size(); i++)
                check({name, "_stage_base"}, sq[i], exp_sb[i]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        check({name, "_wr_addr"}, {25'd0, wr_addr}, 32'd0);
        check({name, "_wr_data"}, {16'd0, wr_data}, 32'd0);
        check({name, "_sb_we"}, {31'd0, stage_base_we}, 32'd0);
        check({name, "_sb_idx"}, {28'd0, stage_base_idx}, 32'd0);
        check({name, "_sb_addr"}, {25'd0, stage_base_addr}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_error"}, {31'd0, error}, 32'd0);
    endtask

    // Spec example image: one stage, one classifier; optional checksum word appended.
    task automatic send_example(input logic [15:0] csum, input bit start_mid);
        logic [15:0] w[6];
        w = '{16'd1, 16'd1, 16'h0010, 16'h0020, 16'h0030, 16'h0040};
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            if (start_mid && i == 3) begin
                @(negedge clk); in_valid = 1'b0; start = 1'b1;
                @(negedge clk); start = 1'b0;
            end
`ifdef LOADER_CHECKSUM_EN
            send_word(w[i], 1'b0, 0);
`else
            send_word(w[i], i == 5, 0);
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(csum, 1'b1, 0);
`endif
    endtask

    initial begin
        vec_t vecs[12];
        int ns[$];
        logic [15:0] exp_d[4];
        vecs = '{
            '{"one_stage",     1,  1, 0, -1, -1,   4, 1'b1, 1'b0},
            '{"two_stage",     2,  2, 0, -1, -1,   8, 1'b1, 1'b0},
            '{"zero_stages",   0,  0, 0, -1, -1,   0, 1'b1, 1'b0},
            '{"max_stages",   16,  0, 0, -1, -1,  16, 1'b1, 1'b0},
            '{"too_many",     17,  0, 0,  0, -2,   0, 1'b0, 1'b1},
            '{"last_on_feat", 1,   1, 0,  3,  3,  -1, 1'b0, 1'b1},
            '{"no_last",       1,  0, 0, -1, -2,  -1, 1'b0, 1'b1},
            '{"last_on_nstg",  2,  1, 1,  0,  0,   0, 1'b0, 1'b1},
            '{"last_on_n",     1,  2, 0,  1,  1,   0, 1'b0, 1'b1},
            '{"zero_no_last",  0,  0, 0, -1, -2,   0, 1'b0, 1'b1},
            '{"exact_fill",    1, 33, 0, -1, -1, 100, 1'b1, 1'b0},
            '{"overflow",      1, 34, 0, 102, -2, 100, 1'b0, 1'b1}
        };
        exp_d = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        foreach (vecs[v]) begin
            ns = '{vecs[v].n0, vecs[v].n1};
            run(vecs[v].name, ns, vecs[v].nstg, 1'b0, 0, vecs[v].stop_at, vecs[v].last_at,
                vecs[v].exp_writes, vecs[v].exp_done, vecs[v].exp_err);
        end

        // Example image, with a start pulse mid-load that must be ignored.
        send_example(16'h00A2, 1'b1);
        @(negedge clk);
`ifndef LOADER_CHECKSUM_EN
        check("ex_last_wr_en", {31'd0, wr_en}, 32'd1);
        check("ex_last_wr_addr", {25'd0, wr_addr}, 32'd3);
        @(negedge clk);
`endif
        check("ex_done", {31'd0, done}, 32'd1);
        check("ex_error", {31'd0, error}, 32'd0);
        check("ex_nwrites", wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++)
            check("ex_write", wq[i], {9'd0, 7'(i), exp_d[i]});
        check("ex_nstage_base", sq.size(), 1);
        if (sq.size() > 0) check("ex_stage_base", sq[0], 32'd0);

`ifdef LOADER_CHECKSUM_EN
        send_example(16'h00A3, 1'b0);
        end_stream();
        check("csum_bad_error", {31'd0, error}, 32'd1);
        check("csum_bad_done", {31'd0, done}, 32'd0);
`endif

        // Two stages N=2,N=0 with in_valid toggling.
        ns = '{2, 0};
        run("toggle", ns, 2, 1'b1, 1, -1, -1, 8, 1'b1, 1'b0);
        check("toggle_sb1", (sq.size() > 1) ? sq[1] : 32'hFFFF_FFFF, {12'd0, 4'd1, 9'd0, 7'd7});

        // Reset in the middle of the feature words.
        pulse_start();
        send_word(16'd1, 1'b0, 0);
        send_word(16'd2, 1'b0, 0);
        send_word(16'h1234, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0; in_valid = 1'b0;
        ns = '{1};
        run("after_reset", ns, 1, 1'b1, 0, -1, -1, 4, 1'b1, 1'b0);

        for (int r = 0; r < 16; r++) begin
            int nstg;
            nstg = $urandom_range(1, 4);
            ns.delete();
            for (int s = 0; s < nstg; s++) ns.push_back($urandom_range(0, 4));
            run("random", ns, nstg, 1'b1, 2, -1, -1, -2, 1'b1, 1'b0);
            check("random_nwrites", wq.size(), exp_pay.size());
            for (int i = 0; i < wq.size() && i < exp_pay.size(); i++)
                check("random_write", wq[i], {9'd0, 7'(i), exp_pay[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
